// File: rtl/f_stage_if.sv
// f_stage_if: instruction ROM bus between the fetch stage and the asynchronous ROM.
interface f_stage_if;
    logic [31:0] i_inst_addr;
    logic [31:0] i_inst_rdata;
    modport master (output i_inst_addr, input i_inst_rdata);
    modport slave (input i_inst_addr, output i_inst_rdata);
endinterface

// File: rtl/f_stage.sv
// f_stage: MIPS fetch stage; PC select, ROM read, AdEL detection and delay-slot/eret annotation.
module f_stage #(
    parameter logic [31:0] PC_RESET  = 32'h0000_3000,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
    parameter logic [31:0] IM_BASE   = 32'h0000_3000,
    parameter logic [31:0] IM_TOP    = 32'h0000_6ffc
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        Req,
    input  logic        D_Eret,
    input  logic [31:0] EPC,
    input  logic        D_IsJump,
    input  logic        D_BranchTaken,
    input  logic [31:0] D_Target,
    f_stage_if.master   rom,
    output logic [31:0] F_PC,
    output logic [31:0] F_IR,
    output logic        F_BD,
    output logic [4:0]  F_ExcCode
);
    logic [31:0] r_pc;
    logic [31:0] w_npc;
    logic        w_adel;
    logic        w_squash;

    always_comb w_npc = Req ? EXC_ENTRY : Stall ? r_pc : D_Eret ? EPC :
                        D_BranchTaken ? D_Target : r_pc + 32'd4;

    always_ff @(posedge Clk) r_pc <= Rst ? PC_RESET : w_npc;

    // eret has no delay slot, so the sequential fetch behind it becomes a bubble
    assign w_squash = D_Eret && !Stall;
    assign w_adel = (r_pc[1:0] != 2'b00) || (r_pc < IM_BASE) || (r_pc > IM_TOP);
    assign rom.i_inst_addr = r_pc;
    assign F_PC = r_pc;
    assign F_IR = (w_squash || w_adel) ? 32'd0 : rom.i_inst_rdata;
    assign F_BD = !w_squash && D_IsJump;
    assign F_ExcCode = (!w_squash && w_adel) ? 5'd4 : 5'd31;
endmodule

// File: tb/tb_f_stage.sv
// tb_f_stage: table-driven check of the fetch stage against hand-computed PC/annotation sequences.
module tb_f_stage;
    logic        Clk = 1'b0;
    logic        Rst, Stall, Req, D_Eret, D_IsJump, D_BranchTaken;
    logic [31:0] EPC, D_Target, F_PC, F_IR;
    logic        F_BD;
    logic [4:0]  F_ExcCode;
    int          n_run = 0;
    int          n_fail = 0;

    f_stage_if rom ();
    assign rom.i_inst_rdata = ~rom.i_inst_addr;

    f_stage dut (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .Req(Req), .D_Eret(D_Eret), .EPC(EPC),
        .D_IsJump(D_IsJump), .D_BranchTaken(D_BranchTaken), .D_Target(D_Target),
        .rom(rom), .F_PC(F_PC), .F_IR(F_IR), .F_BD(F_BD), .F_ExcCode(F_ExcCode)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        rst, stall, req, eret;
        logic [31:0] epc;
        logic        isj, tk;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic        bd;
        logic [4:0]  exc;
        logic        irz;
    } vec_t;

    vec_t v[27];

    function automatic vec_t mk(input logic rst, stall, req, eret, input logic [31:0] epc,
                                input logic isj, tk, input logic [31:0] tgt, pc,
                                input logic bd, input logic [4:0] exc, input logic irz);
        vec_t r;
        r.rst = rst; r.stall = stall; r.req = req; r.eret = eret; r.epc = epc;
        r.isj = isj; r.tk = tk; r.tgt = tgt; r.pc = pc; r.bd = bd; r.exc = exc; r.irz = irz;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] pc, input logic bd,
                           input logic [4:0] exc, input logic irz);
        chk({tag, " F_PC"}, F_PC, pc);
        chk({tag, " addr"}, rom.i_inst_addr, pc);
        chk({tag, " F_IR"}, F_IR, irz ? 32'd0 : ~pc);
        chk({tag, " F_BD"}, {31'd0, F_BD}, {31'd0, bd});
        chk({tag, " F_ExcCode"}, {27'd0, F_ExcCode}, {27'd0, exc});
    endtask

    task automatic drive(input logic rst, stall, req, eret, input logic [31:0] epc,
                         input logic isj, tk, input logic [31:0] tgt);
        Rst = rst; Stall = stall; Req = req; D_Eret = eret; EPC = epc;
        D_IsJump = isj; D_BranchTaken = tk; D_Target = tgt;
    endtask

    initial begin
        v[0]  = mk(0,0,0,0,0,          0,0,0,           32'h3000,0,31,0);
        v[1]  = mk(0,0,0,0,0,          0,0,0,           32'h3004,0,31,0);
        v[2]  = mk(0,0,0,0,0,          0,0,0,           32'h3008,0,31,0);
        v[3]  = mk(0,0,0,0,0,          0,0,0,           32'h300c,0,31,0);
        v[4]  = mk(0,0,0,0,0,          1,1,32'h3100,    32'h3010,1,31,0);
        v[5]  = mk(0,0,0,0,0,          0,0,0,           32'h3100,0,31,0);
        v[6]  = mk(0,0,0,0,0,          1,1,32'h3102,    32'h3104,1,31,0);
        v[7]  = mk(0,0,0,0,0,          1,1,32'h7000,    32'h3102,1,4,1);
        v[8]  = mk(0,0,0,0,0,          0,1,32'h3020,    32'h7000,0,4,1);
        v[9]  = mk(0,1,0,0,0,          0,0,0,           32'h3020,0,31,0);
        v[10] = mk(0,1,0,0,0,          0,0,0,           32'h3020,0,31,0);
        v[11] = mk(0,1,1,0,0,          0,0,0,           32'h3020,0,31,0);
        v[12] = mk(0,0,0,0,0,          1,1,32'h4200,    32'h4180,1,31,0);
        v[13] = mk(0,1,0,1,32'h3040,   0,0,0,           32'h4200,0,31,0);
        v[14] = mk(0,0,0,1,32'h3040,   1,0,0,           32'h4200,0,31,1);
        v[15] = mk(0,0,0,0,0,          1,1,32'h1000,    32'h3040,1,31,0);
        v[16] = mk(0,0,0,1,32'h3050,   0,0,0,           32'h1000,0,31,1);
        v[17] = mk(0,0,1,0,0,          1,1,32'h3100,    32'h3050,1,31,0);
        v[18] = mk(1,0,1,0,0,          0,0,0,           32'h4180,0,31,0);
        v[19] = mk(0,0,0,0,0,          0,0,0,           32'h3000,0,31,0);
        v[20] = mk(0,0,0,0,0,          1,1,32'h6ffc,    32'h3004,1,31,0);
        v[21] = mk(0,0,0,0,0,          0,0,0,           32'h6ffc,0,31,0);
        v[22] = mk(0,0,0,0,0,          1,1,32'h2ffc,    32'h7000,1,4,1);
        v[23] = mk(0,0,0,0,0,          0,0,0,           32'h2ffc,0,4,1);
        v[24] = mk(0,1,0,0,0,          1,1,32'h5000,    32'h3000,1,31,0);
        v[25] = mk(0,0,0,0,0,          0,0,0,           32'h3000,0,31,0);
        v[26] = mk(0,0,0,0,0,          0,0,0,           32'h3004,0,31,0);
        drive(1,0,0,0,0,0,0,0);
        @(posedge Clk);
        #1;
        for (int i = 0; i < 27; i++) begin
            drive(v[i].rst, v[i].stall, v[i].req, v[i].eret, v[i].epc, v[i].isj, v[i].tk, v[i].tgt);
            #1;
            chk_all($sformatf("vec%0d", i), v[i].pc, v[i].bd, v[i].exc, v[i].irz);
            @(posedge Clk);
            #1;
        end
        // reset during a stall with a pending eret leaves no residue
        drive(0,1,0,0,0,0,0,0);
        #1;
        chk_all("stall0", 32'h3008, 0, 31, 0);
        @(posedge Clk);
        #1;
        drive(1,1,0,1,32'h3040,0,0,0);
        #1;
        chk_all("rst_stall", 32'h3008, 0, 31, 0);
        @(posedge Clk);
        #1;
        drive(0,0,0,0,0,0,0,0);
        #1;
        chk_all("post_rst0", 32'h3000, 0, 31, 0);
        @(posedge Clk);
        #1;
        chk_all("post_rst1", 32'h3004, 0, 31, 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/f_stage.md
# f_stage

Instruction-fetch stage of the five-stage MIPS pipeline with precise exceptions. Holds the program counter, selects the next PC (sequential, branch/jump, `eret` return, exception entry), and reads the instruction ROM. Detects fetch address errors and annotates each fetched instruction with PC, delay-slot flag and exception code. Sits directly upstream of the F/D pipeline register, which latches this stage's outputs each cycle.

## Interface
Parameters:
- `PC_RESET`, `32'h0000_3000`: PC after reset.
- `EXC_ENTRY`, `32'h0000_4180`: exception/interrupt handler entry.
- `IM_BASE`, `32'h0000_3000`: lowest legal fetch address.
- `IM_TOP`, `32'h0000_6ffc`: highest legal fetch address (inclusive).

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `Clk` in 1: clock, all state updates on rising edge.
- `Rst` in 1: synchronous active-high reset.
- `Stall` in 1: hazard unit; hold the PC.
- `Req` in 1: exception/interrupt taken this cycle; redirect to `EXC_ENTRY`.
- `D_Eret` in 1: D-stage instruction is `eret`.
- `EPC` in 32: CP0 EPC, forwarded value.
- `D_IsJump` in 1: D-stage instruction is any branch/jump, taken or not.
- `D_BranchTaken` in 1: D-stage branch/jump resolved taken.
- `D_Target` in 32: D-stage branch/jump target.
- `i_inst_addr` out 32: instruction ROM address (= PC).
- `i_inst_rdata` in 32: ROM data, combinational from `i_inst_addr`.
- `F_PC` out 32, `F_IR` out 32, `F_BD` out 1, `F_ExcCode` out 5: annotated fetch, consumed by the F/D register.

## Operation
- State: 32-bit `PC` register, reset to `PC_RESET`.
- Next-PC priority, highest first:
  1. `Rst` -> `PC_RESET`.
  2. `Req` -> `EXC_ENTRY` (overrides `Stall`).
  3. `Stall` -> hold.
  4. `D_Eret` -> `EPC`.
  5. `D_BranchTaken` -> `D_Target`.
  6. Otherwise `PC + 4`, modulo 2^32, no wrap detection.
- Address error (AdEL): `PC[1:0] != 0` or `PC < IM_BASE` or `PC > IM_TOP`, unsigned compare.
- Outputs, all combinational from `PC` and inputs:
  - `F_PC = PC`.
  - `i_inst_addr = PC`.
  - `F_IR`: `i_inst_rdata`; 0 on AdEL.
  - `F_ExcCode`: 4 (AdEL) on address error; 31 (Null) otherwise.
  - `F_BD = D_IsJump`, i.e. the fetched instruction is a delay slot.
- `eret` squash:
  - Applies when `D_Eret && !Stall`.
  - `eret` has no delay slot; the sequential instruction behind it is discarded.
  - Forces `F_IR = 0`, `F_BD = 0`, `F_ExcCode = 31`, overriding AdEL.
  - `F_PC` still shows `PC`.
- `eret` with `Stall`: no redirect and no squash; it retries when the stall clears.
- Simultaneous `Req` and `D_Eret` or branch: `Req` wins. The F/D register flushes on `Req`, so F outputs that cycle are don't-care.
- Branch whose delay slot raises AdEL: `F_BD = 1` and `F_ExcCode = 4`, so EPC can be rewound correctly downstream.

## Timing
- After a rising edge with `Rst = 1`:
  - `PC = 0x3000`, `F_PC = 0x3000`, `F_BD = 0` (given `D_IsJump = 0`).
  - `F_ExcCode = 31`, `F_IR = ROM[0x3000]`.
- Latency: a redirect requested in cycle N (`Req`, `eret`, or taken branch) appears on `F_PC` in cycle N+1. For a taken branch, the instruction fetched in cycle N is its delay slot and proceeds.
- `Stall` high for k cycles: `PC` and all F outputs are held (given stable inputs) for k cycles; the increment resumes on the first edge with `Stall = 0`.
- Reset mid-stall or mid-redirect: `Rst` wins on that edge, no residual state.
- No internal handshake. The ROM is asynchronous and read every cycle, including stalls.

## Test plan
- Reset then 3 free cycles -> `F_PC` = 0x3000, 0x3004, 0x3008, 0x300c; `F_ExcCode` = 31 each cycle.
- At PC 0x3010, `D_IsJump = 1`, `D_BranchTaken = 1`, `D_Target = 0x3100` -> that cycle `F_BD = 1`, `F_PC = 0x3010`; next cycle `F_PC = 0x3100`, `F_BD = 0`.
- `D_Target = 0x3102` taken -> next cycle `F_ExcCode = 4`, `F_IR = 0`. Repeat with `D_Target = 0x7000` -> `F_ExcCode = 4`.
- `Stall` held 3 cycles at PC 0x3020 -> `F_PC` stays 0x3020. Assert `Req` during the stall -> next cycle `F_PC = 0x4180`.
- `D_Eret = 1`, `EPC = 0x3040` at PC 0x4200 -> that cycle `F_IR = 0`, `F_ExcCode = 31`; next cycle `F_PC = 0x3040`. Same with `Stall = 1` -> PC holds 0x4200, no squash.
- `Req` and `D_BranchTaken` (target 0x3100) in the same cycle -> next `F_PC = 0x4180`. `Rst` with `Req` -> next `F_PC = 0x3000`.
